// File: rtl/mont_mul_dsr.sv
// mont_mul_dsr: digit-serial Montgomery multiplier, z = x*y*2^(-K) mod m.
// Retires D bits of x per cycle over N = K/D iterations, then applies one
// conditional final subtract. The modulus and its digit inverse are taken
// per request, so any odd K-bit modulus can be served.
// Optional feature macro: MONT_MUL_OPERAND_CHECK_EN
//   When defined, a request whose modulus is even or whose m_inv does not
//   satisfy m*m_inv == -1 (mod 2^D) is answered after one cycle with
//   z=0, err=1. When undefined, err is always 0.
module mont_mul_dsr #(
  parameter int K = 256,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic [K-1:0] m,
  input  logic [D-1:0] m_inv,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [K-1:0] z,
  output logic         err
);

  localparam int N  = K / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Wide enough for P + x_i*Y + q*M with no truncation before the shift.
  localparam int AW = K + D + 2;

  // ERR is only reachable when the operand check is compiled in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    SUB  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_n;
  logic [K-1:0]    x_r;
  logic [K-1:0]    y_r;
  logic [K-1:0]    m_r;
  logic [D-1:0]    m_inv_r;
  logic [K:0]      p_r;
  logic [CW-1:0]   cnt_r;
  logic [K-1:0]    z_r;
  logic            err_r;
  logic            rsp_valid_r;
  logic            req_ready_r;

  logic            accept_s;
  logic            chk_ok_s;
  logic [D-1:0]    x_dig_s;
  logic [D-1:0]    q_s;
  logic [AW-1:0]   a_s;
  logic [AW-1:0]   t_s;
  logic [K:0]      p_nxt_s;

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign z         = z_r;
  assign err       = err_r;

  assign accept_s  = req_valid && req_ready_r;

`ifdef MONT_MUL_OPERAND_CHECK_EN
  // Operand sanity: odd modulus and a consistent digit inverse.
  assign chk_ok_s = m[0] && (D'(m[D-1:0] * m_inv) == {D{1'b1}});
`else
  assign chk_ok_s = 1'b1;
`endif

  // One Montgomery digit step: add x_i*Y, pick q to clear the low digit, add q*M, shift.
  always_comb begin
    x_dig_s = x_r[D-1:0];
    a_s     = AW'(p_r) + AW'(y_r) * AW'(x_dig_s);
    q_s     = D'(a_s[D-1:0] * m_inv_r);
    t_s     = a_s + AW'(m_r) * AW'(q_s);
    p_nxt_s = (K+1)'(t_s >> D);
  end

  // Next-state decode for the operation sequencer.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (chk_ok_s) begin
            state_n = RUN;
          end else begin
            state_n = ERR;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(N - 1)) begin
          state_n = SUB;
        end else begin
          state_n = RUN;
        end
      end
      SUB:  state_n = DONE;
      ERR:  state_n = DONE;
      DONE: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, operand capture, digit iteration and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      x_r         <= {K{1'b0}};
      y_r         <= {K{1'b0}};
      m_r         <= {K{1'b0}};
      m_inv_r     <= {D{1'b0}};
      p_r         <= {(K+1){1'b0}};
      cnt_r       <= {CW{1'b0}};
      z_r         <= {K{1'b0}};
      err_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= state_n;
      req_ready_r <= (state_n == IDLE);
      rsp_valid_r <= (state_n == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r     <= x;
            y_r     <= y;
            m_r     <= m;
            m_inv_r <= m_inv;
            p_r     <= {(K+1){1'b0}};
            cnt_r   <= {CW{1'b0}};
          end
        end
        RUN: begin
          p_r   <= p_nxt_s;
          x_r   <= x_r >> D;
          cnt_r <= cnt_r + CW'(1);
        end
        SUB: begin
          // P < 2m, so one subtract brings it into [0, m).
          if (p_r >= {1'b0, m_r}) begin
            z_r <= K'(p_r - {1'b0, m_r});
          end else begin
            z_r <= p_r[K-1:0];
          end
          err_r <= 1'b0;
        end
        ERR: begin
          z_r   <= {K{1'b0}};
          err_r <= 1'b1;
        end
        DONE: begin
          z_r <= z_r;
        end
        default: begin
          z_r <= z_r;
        end
      endcase
    end
  end

endmodule
